// File: rtl/dram_port_arbiter.sv
`timescale 1ns/1ps
// Shares one DRAM controller port between PTW (M0, fixed priority, lockable) and CPU/DMA
// (M1/M2, round-robin); a completion watchdog aborts with an error if the DRAM never answers.
module dram_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic [2:0]            w_req,
   input  logic [2:0]            w_we,
   input  logic [3*ADDR_W-1:0]   w_addr,
   input  logic [95:0]           w_wdata,
   input  logic [11:0]           w_wstrb,
   input  logic                  w_lock,
   output logic [2:0]            w_ack,
   output logic [2:0]            w_err,
   output logic [31:0]           w_rdata,
   output logic [1:0]            w_grant,
   output logic                  w_dram_req,
   output logic                  w_dram_we,
   output logic [ADDR_W-1:0]     w_dram_addr,
   output logic [31:0]           w_dram_wdata,
   output logic [3:0]            w_dram_wstrb,
   input  logic                  w_dram_busy,
   input  logic                  w_dram_done,
   input  logic [31:0]           w_dram_rdata
);

   localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [1:0]  GRANT_NONE = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_wdog;
   logic [1:0]          r_grant;
   logic                r_rr_m2;
   logic                r_lock;
   logic                r_lock_req;
   logic                r_err;
   logic                r_cmd_we;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic [31:0]         r_cmd_wdata;
   logic [3:0]          r_cmd_wstrb;
   logic [31:0]         r_rdata;

   logic [2:0]          w_elig;
   logic                w_win_valid;
   logic [1:0]          w_win;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [31:0]         w_sel_wdata;
   logic [3:0]          w_sel_wstrb;
   logic                w_timeout;

   // While M0 holds the lock, only M0 may win
   assign w_elig      = r_lock ? {2'b00, w_req[0]} : w_req;
   assign w_win_valid = |w_elig;
   assign w_timeout   = (r_wdog == CNT_W'(TIMEOUT - 1));

   always_comb begin
      w_win = 2'd0;
      if (w_elig[0])                    w_win = 2'd0;
      else if (w_elig[1] && w_elig[2])  w_win = r_rr_m2 ? 2'd2 : 2'd1;
      else if (w_elig[1])               w_win = 2'd1;
      else if (w_elig[2])               w_win = 2'd2;
   end

   always_comb begin
      w_sel_we    = w_we[0];
      w_sel_addr  = w_addr[0 +: ADDR_W];
      w_sel_wdata = w_wdata[0 +: 32];
      w_sel_wstrb = w_wstrb[0 +: 4];
      case (w_win)
         2'd1: begin
            w_sel_we    = w_we[1];
            w_sel_addr  = w_addr[ADDR_W +: ADDR_W];
            w_sel_wdata = w_wdata[32 +: 32];
            w_sel_wstrb = w_wstrb[4 +: 4];
         end
         2'd2: begin
            w_sel_we    = w_we[2];
            w_sel_addr  = w_addr[2*ADDR_W +: ADDR_W];
            w_sel_wdata = w_wdata[64 +: 32];
            w_sel_wstrb = w_wstrb[8 +: 4];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_win_valid)              w_state_nxt = S_ISSUE;
         S_ISSUE: if (!w_dram_busy)             w_state_nxt = S_WAIT;
         S_WAIT:  if (w_dram_done || w_timeout) w_state_nxt = S_RESP;
         S_RESP:                                w_state_nxt = S_IDLE;
         default:                               w_state_nxt = S_IDLE;
      endcase
   end

   // Command strobe follows busy in the same cycle so it fires exactly when busy falls
   always_comb begin
      w_dram_req = 1'b0;
      w_ack      = 3'b000;
      w_err      = 3'b000;
      if (r_state == S_ISSUE) w_dram_req = ~w_dram_busy;
      if (r_state == S_RESP) begin
         case (r_grant)
            2'd0:    w_ack = 3'b001;
            2'd1:    w_ack = 3'b010;
            2'd2:    w_ack = 3'b100;
            default: w_ack = 3'b000;
         endcase
      end
      if (r_err) w_err = w_ack;
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_wdog      <= '0;
         r_grant     <= GRANT_NONE;
         r_rr_m2     <= 1'b0;
         r_lock      <= 1'b0;
         r_lock_req  <= 1'b0;
         r_err       <= 1'b0;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_cmd_wstrb <= '0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_grant     <= w_win;
                  r_cmd_we    <= w_sel_we;
                  r_cmd_addr  <= w_sel_addr;
                  r_cmd_wdata <= w_sel_wdata;
                  r_cmd_wstrb <= w_sel_wstrb;
                  r_lock_req  <= w_lock;
               end
            end
            S_ISSUE: if (!w_dram_busy) r_wdog <= '0;
            S_WAIT: begin
               if (r_wdog != CNT_W'(TIMEOUT)) r_wdog <= r_wdog + CNT_W'(1);
               if (w_dram_done) begin
                  r_err <= 1'b0;
                  if (!r_cmd_we) r_rdata <= w_dram_rdata;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            S_RESP: begin
               if (r_grant == 2'd1)      r_rr_m2 <= 1'b1;
               else if (r_grant == 2'd2) r_rr_m2 <= 1'b0;
               if (r_grant == 2'd0)      r_lock  <= r_lock_req;
               r_grant <= GRANT_NONE;
            end
            default: ;
         endcase
      end
   end

   assign w_rdata      = r_rdata;
   assign w_grant      = r_grant;
   assign w_dram_we    = r_cmd_we;
   assign w_dram_addr  = r_cmd_addr;
   assign w_dram_wdata = r_cmd_wdata;
   assign w_dram_wstrb = r_cmd_wstrb;

endmodule
